// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO slave and its interrupt controller:
// register word offsets and default instance sizes.
package gpio_pkg;

  localparam int DEF_N_PINS = 8;
  localparam int DEF_FILT_W = 4;

  localparam logic [31:0] ADDR_DATA_IN = 32'd0;
  localparam logic [31:0] ADDR_RISE_EN = 32'd1;
  localparam logic [31:0] ADDR_FALL_EN = 32'd2;
  localparam logic [31:0] ADDR_MASK    = 32'd3;
  localparam logic [31:0] ADDR_PENDING = 32'd4;
  localparam logic [31:0] ADDR_FILTER  = 32'd5;

  // The map is dense from zero, so anything past FILTER is unmapped.
  function automatic logic addr_mapped(input logic [31:0] addr);
    return addr <= ADDR_FILTER;
  endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One GPIO input lane: 2-flop synchronizer, persistence glitch filter and
// edge detection on the filtered value.
module gpio_in_filter #(
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pin,
  input  logic [FILT_W-1:0] thresh,
  input  logic              cnt_clr,
  output logic              f,
  output logic              rise,
  output logic              fall
);

  logic              sync_q;
  logic              s;
  logic              f_d;
  logic [FILT_W-1:0] cnt;
  logic [FILT_W:0]   cnt_next;
  logic [FILT_W:0]   thr;

  // Thresholds of 0 and 1 both accept a change on the first differing sample.
  assign thr      = (thresh == '0) ? {{FILT_W{1'b0}}, 1'b1} : {1'b0, thresh};
  assign cnt_next = {1'b0, cnt} + {{FILT_W{1'b0}}, 1'b1};

  // The counter measures how long s has disagreed with f; f only moves once
  // the disagreement has persisted for the full threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
      f      <= 1'b0;
      f_d    <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= pin;
      s      <= sync_q;
      f_d    <= f;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (s != f) begin
        if (cnt_next >= thr) begin
          f   <= s;
          cnt <= '0;
        end else begin
          cnt <= cnt_next[FILT_W-1:0];
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = f & ~f_d;
  assign fall = ~f & f_d;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO edge-interrupt controller: per-pin filtered inputs, enable/mask/pending
// registers with write-1-to-clear, registered read port and interrupt line.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int N_PINS = DEF_N_PINS,
  parameter int FILT_W = DEF_FILT_W
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_WEnable,
  input  logic [31:0]       i_WAddr,
  input  logic [31:0]       i_WData,
  input  logic              i_REnable,
  input  logic [31:0]       i_RAddr,
  output logic [31:0]       o_RData,
  output logic              o_Err,
  input  logic [N_PINS-1:0] pin,
  output logic              o_Irq
);

  logic [N_PINS-1:0] rise_en;
  logic [N_PINS-1:0] fall_en;
  logic [N_PINS-1:0] mask;
  logic [N_PINS-1:0] pending;
  logic [FILT_W-1:0] filter;

  logic [N_PINS-1:0] f_vec;
  logic [N_PINS-1:0] rise_vec;
  logic [N_PINS-1:0] fall_vec;
  logic [N_PINS-1:0] set_ev;
  logic [N_PINS-1:0] w1c;
  logic [31:0]       rd_mux;

  logic wr_rise_en;
  logic wr_fall_en;
  logic wr_mask;
  logic wr_pending;
  logic wr_filter;
  logic unused_wdata;

  assign wr_rise_en   = i_WEnable && (i_WAddr == ADDR_RISE_EN);
  assign wr_fall_en   = i_WEnable && (i_WAddr == ADDR_FALL_EN);
  assign wr_mask      = i_WEnable && (i_WAddr == ADDR_MASK);
  assign wr_pending   = i_WEnable && (i_WAddr == ADDR_PENDING);
  assign wr_filter    = i_WEnable && (i_WAddr == ADDR_FILTER);
  assign unused_wdata = ^i_WData;

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_in_filter #(
      .FILT_W (FILT_W)
    ) u_filt (
      .clk     (i_Clk),
      .rst_n   (i_Rst),
      .pin     (pin[i]),
      .thresh  (filter),
      .cnt_clr (wr_filter),
      .f       (f_vec[i]),
      .rise    (rise_vec[i]),
      .fall    (fall_vec[i])
    );
  end

  assign set_ev = (rise_vec & rise_en) | (fall_vec & fall_en);
  assign w1c    = wr_pending ? i_WData[N_PINS-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (i_RAddr)
      ADDR_DATA_IN: rd_mux[N_PINS-1:0] = f_vec;
      ADDR_RISE_EN: rd_mux[N_PINS-1:0] = rise_en;
      ADDR_FALL_EN: rd_mux[N_PINS-1:0] = fall_en;
      ADDR_MASK:    rd_mux[N_PINS-1:0] = mask;
      ADDR_PENDING: rd_mux[N_PINS-1:0] = pending;
      ADDR_FILTER:  rd_mux[FILT_W-1:0] = filter;
      default:      rd_mux = '0;
    endcase
  end

  // Reads sample the registers before this edge's writes land, and a new
  // edge event overrides a simultaneous clear of the same pending bit.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      rise_en <= '0;
      fall_en <= '0;
      mask    <= '0;
      pending <= '0;
      filter  <= '0;
      o_RData <= '0;
      o_Err   <= 1'b0;
      o_Irq   <= 1'b0;
    end else begin
      if (wr_rise_en) rise_en <= i_WData[N_PINS-1:0];
      if (wr_fall_en) fall_en <= i_WData[N_PINS-1:0];
      if (wr_mask)    mask    <= i_WData[N_PINS-1:0];
      if (wr_filter)  filter  <= i_WData[FILT_W-1:0];
      pending <= (pending & ~w1c) | set_ev;
      o_Irq   <= |(pending & mask);
      if (i_REnable) o_RData <= rd_mux;
      o_Err <= (i_REnable && !addr_mapped(i_RAddr)) ||
               (i_WEnable && !addr_mapped(i_WAddr));
    end
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: directed scenarios plus random traffic, every cycle
// compared against a rule-level model of the controller.
module tb_gpio_irq_ctrl;

  localparam int NP = 8;
  localparam int FW = 4;

  logic          i_Clk = 1'b0;
  logic          i_Rst;
  logic          i_WEnable;
  logic [31:0]   i_WAddr;
  logic [31:0]   i_WData;
  logic          i_REnable;
  logic [31:0]   i_RAddr;
  logic [31:0]   o_RData;
  logic          o_Err;
  logic [NP-1:0] pin;
  logic          o_Irq;

  int checks = 0;
  int errors = 0;

  // Model state: s is the pin seen two edges late, streak counts consecutive
  // samples where s disagreed with f, up/dn flag an f change on the last edge.
  logic [NP-1:0] m_s1, m_s2, m_f, m_up, m_dn;
  logic [NP-1:0] m_rise_en, m_fall_en, m_mask, m_pending;
  logic [FW-1:0] m_filter;
  logic [31:0]   m_rdata;
  logic          m_err, m_irq;
  int            m_streak [NP];

  gpio_irq_ctrl #(
    .N_PINS (NP),
    .FILT_W (FW)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_WEnable (i_WEnable),
    .i_WAddr   (i_WAddr),
    .i_WData   (i_WData),
    .i_REnable (i_REnable),
    .i_RAddr   (i_RAddr),
    .o_RData   (o_RData),
    .o_Err     (o_Err),
    .pin       (pin),
    .o_Irq     (o_Irq)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_f = '0; m_up = '0; m_dn = '0;
    m_rise_en = '0; m_fall_en = '0; m_mask = '0; m_pending = '0;
    m_filter = '0; m_rdata = '0; m_err = 1'b0; m_irq = 1'b0;
    for (int i = 0; i < NP; i++) m_streak[i] = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    case (addr)
      32'd0:   return {24'b0, m_f};
      32'd1:   return {24'b0, m_rise_en};
      32'd2:   return {24'b0, m_fall_en};
      32'd3:   return {24'b0, m_mask};
      32'd4:   return {24'b0, m_pending};
      32'd5:   return {28'b0, m_filter};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0]   rd;
    logic          err, irq;
    logic [NP-1:0] w1c, pend, f_new, up, dn;
    int            thr;
    thr  = (m_filter < 2) ? 1 : int'(m_filter);
    rd   = i_REnable ? model_read(i_RAddr) : m_rdata;
    err  = (i_REnable && i_RAddr > 32'd5) || (i_WEnable && i_WAddr > 32'd5);
    irq  = |(m_pending & m_mask);
    w1c  = (i_WEnable && i_WAddr == 32'd4) ? i_WData[NP-1:0] : '0;
    pend = (m_pending & ~w1c) | (m_up & m_rise_en) | (m_dn & m_fall_en);
    f_new = m_f; up = '0; dn = '0;
    for (int i = 0; i < NP; i++) begin
      if (i_WEnable && i_WAddr == 32'd5) begin
        m_streak[i] = 0;
      end else if (m_s2[i] != m_f[i]) begin
        m_streak[i]++;
        if (m_streak[i] >= thr) begin
          f_new[i] = m_s2[i];
          up[i] = m_s2[i];
          dn[i] = ~m_s2[i];
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    if (i_WEnable) begin
      case (i_WAddr)
        32'd1:   m_rise_en = i_WData[NP-1:0];
        32'd2:   m_fall_en = i_WData[NP-1:0];
        32'd3:   m_mask    = i_WData[NP-1:0];
        32'd5:   m_filter  = i_WData[FW-1:0];
        default: ;
      endcase
    end
    m_s2 = m_s1; m_s1 = pin; m_f = f_new; m_up = up; m_dn = dn;
    m_pending = pend; m_rdata = rd; m_err = err; m_irq = irq;
  endtask

  task automatic cycle();
    @(posedge i_Clk);
    if (!i_Rst) model_reset();
    else model_edge();
    #1;
    check_output("irq", {31'b0, o_Irq}, {31'b0, m_irq});
    check_output("err", {31'b0, o_Err}, {31'b0, m_err});
    check_output("rdata", o_RData, m_rdata);
    i_WEnable = 1'b0;
    i_REnable = 1'b0;
  endtask

  task automatic apply_stimulus(input logic wen, input logic [31:0] waddr, input logic [31:0] wdata,
                                input logic ren, input logic [31:0] raddr);
    i_WEnable = wen; i_WAddr = waddr; i_WData = wdata;
    i_REnable = ren; i_RAddr = raddr;
    cycle();
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    apply_stimulus(1'b1, addr, data, 1'b0, 32'd0);
  endtask

  task automatic read_reg(input logic [31:0] addr);
    apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1, addr);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    i_Rst = 1'b1; i_WEnable = 1'b0; i_WAddr = '0; i_WData = '0;
    i_REnable = 1'b0; i_RAddr = '0; pin = '0;
    model_reset();
    #1 i_Rst = 1'b0;
    #1;
    check_output("reset_irq", {31'b0, o_Irq}, 32'd0);
    check_output("reset_err", {31'b0, o_Err}, 32'd0);
    check_output("reset_rdata", o_RData, 32'd0);
    wait_cycles(2);
    i_Rst = 1'b1;
    wait_cycles(2);

    // Unfiltered rising edge on pin 0: pending at k+3, irq at k+4.
    write_reg(32'd1, 32'h01);
    write_reg(32'd3, 32'h01);
    write_reg(32'd5, 32'h00);
    pin[0] = 1'b1;
    wait_cycles(4);
    check_output("irq_before_k4", {31'b0, o_Irq}, 32'd0);
    wait_cycles(1);
    check_output("irq_at_k4", {31'b0, o_Irq}, 32'd1);
    read_reg(32'd4);
    check_output("pending_rise", o_RData, 32'h01);

    // Filtered falling edges on pin 1: a short glitch is rejected.
    pin[1] = 1'b1;
    wait_cycles(8);
    write_reg(32'd5, 32'h04);
    write_reg(32'd2, 32'h02);
    write_reg(32'd4, 32'hFF);
    pin[1] = 1'b0;
    wait_cycles(3);
    pin[1] = 1'b1;
    wait_cycles(10);
    read_reg(32'd4);
    check_output("pending_glitch", o_RData, 32'h00);
    pin[1] = 1'b0;
    wait_cycles(5);
    pin[1] = 1'b1;
    wait_cycles(10);
    read_reg(32'd4);
    check_output("pending_filtered", o_RData, 32'h02);
    pin[1] = 1'b0;
    wait_cycles(10);

    // Mask gates only the interrupt line.
    write_reg(32'd3, 32'h00);
    write_reg(32'd2, 32'h03);
    pin[0] = 1'b0;
    wait_cycles(12);
    read_reg(32'd4);
    check_output("pending_both", o_RData, 32'h03);
    check_output("irq_masked", {31'b0, o_Irq}, 32'd0);
    write_reg(32'd3, 32'h02);
    wait_cycles(2);
    check_output("irq_unmasked", {31'b0, o_Irq}, 32'd1);
    write_reg(32'd4, 32'h02);
    wait_cycles(2);
    read_reg(32'd4);
    check_output("pending_w1c", o_RData, 32'h01);
    check_output("irq_after_w1c", {31'b0, o_Irq}, 32'd0);

    // W1C on the same edge as a new rising event: set wins.
    write_reg(32'd5, 32'h00);
    wait_cycles(4);
    pin[0] = 1'b1;
    wait_cycles(3);
    write_reg(32'd4, 32'h01);
    read_reg(32'd4);
    check_output("pending_set_wins", o_RData, 32'h01);

    // Unmapped accesses and read-during-write.
    read_reg(32'd7);
    check_output("unmapped_rdata", o_RData, 32'd0);
    check_output("unmapped_rd_err", {31'b0, o_Err}, 32'd1);
    wait_cycles(1);
    check_output("err_one_cycle", {31'b0, o_Err}, 32'd0);
    write_reg(32'd9, 32'hFFFF_FFFF);
    check_output("unmapped_wr_err", {31'b0, o_Err}, 32'd1);
    for (int a = 0; a < 6; a++) read_reg(32'(a));
    apply_stimulus(1'b1, 32'd3, 32'h5A, 1'b1, 32'd3);
    check_output("rd_during_wr", o_RData, 32'h02);
    read_reg(32'd3);
    check_output("rd_after_wr", o_RData, 32'h5A);

    // Fill pending, then reset in the middle of a filter count.
    write_reg(32'd1, 32'hFF);
    write_reg(32'd2, 32'hFF);
    write_reg(32'd3, 32'hFF);
    pin = ~pin;
    wait_cycles(8);
    read_reg(32'd4);
    check_output("pending_all", o_RData, 32'hFF);
    write_reg(32'd5, 32'h06);
    pin = 8'hFF;
    wait_cycles(4);
    i_Rst = 1'b0;
    #1;
    check_output("async_irq", {31'b0, o_Irq}, 32'd0);
    check_output("async_rdata", o_RData, 32'd0);
    check_output("async_err", {31'b0, o_Err}, 32'd0);
    model_reset();
    wait_cycles(3);
    i_Rst = 1'b1;
    wait_cycles(20);
    check_output("irq_after_reset", {31'b0, o_Irq}, 32'd0);
    read_reg(32'd4);
    check_output("pending_after_reset", o_RData, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic        wen, ren;
      logic [31:0] wa, ra;
      if ($urandom_range(0, 3) == 0) pin = pin ^ (8'(1) << $urandom_range(0, NP - 1));
      wen = ($urandom_range(0, 3) == 0);
      ren = ($urandom_range(0, 2) == 0);
      wa = 32'($urandom_range(0, 7));
      ra = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) wa = 32'h8000_0004;
      if ($urandom_range(0, 15) == 0) ra = 32'h0001_0003;
      apply_stimulus(wen, wa, $urandom, ren, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
